// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, flag bit positions and controller state encoding for the ALU issue controller.
package alu_ctrl_pkg;

  localparam int ANDS = 1;
  localparam int ORRS = 2;
  localparam int EORS = 3;
  localparam int BICS = 4;
  localparam int ADCS = 5;
  localparam int ADDS = 6;
  localparam int SBCS = 7;
  localparam int SUBS = 8;
  localparam int RSBS = 9;
  localparam int MULS = 10;
  localparam int LSLS = 11;
  localparam int LSRS = 12;
  localparam int ASRS = 13;
  localparam int RORS = 14;
  localparam int MVNS = 15;
  localparam int MOVS = 16;
  localparam int TST  = 17;
  localparam int CMP  = 18;

  localparam int MAX_OP = 18;

  localparam int NEG   = 0;
  localparam int ZERO  = 1;
  localparam int CARRY = 2;
  localparam int OVF   = 3;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  function automatic logic op_legal(input logic [31:0] op);
    return (op >= 32'd1) && (op <= 32'(MAX_OP));
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// Two-way round-robin arbiter with an eligibility mask; the pointer remembers the last winner.
// Requester 0 wins the first tie after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);

  logic       r_last;
  logic [1:0] w_req;

  assign w_req = i_req & i_mask;

  always_comb begin
    o_gnt = 2'b00;
    case (w_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_upd && (o_gnt != 2'b00)) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one ALU between two requesters: round-robin issue, one-cycle opcode drive, tagged response.
// Optional grant locking is compiled in with the ALU_LOCK_EN macro.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [1:0]          req_lock,
  output logic [OP_W-1:0]     alu_instruction,
  output logic [DATA_W-1:0]   alu_num1,
  output logic [DATA_W-1:0]   alu_num2,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [3:0]          alu_flags,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [3:0]          rsp_flags,
  output logic                rsp_err,
  output logic                busy
);

  state_t              r_state, w_state_nxt;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a, r_b;
  logic                r_id;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [3:0]          r_rsp_flags;
  logic                r_rsp_err;

  logic [1:0]          w_mask, w_gnt;
  logic                w_gid, w_acc, w_legal;
  logic [OP_W-1:0]     w_op_sel;
  logic [DATA_W-1:0]   w_a_sel, w_b_sel;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (req_valid),
    .i_mask (w_mask),
    .i_upd  (w_acc),
    .o_gnt  (w_gnt)
  );

  assign w_gid     = w_gnt[1];
  assign req_ready = (r_state == IDLE) ? w_gnt : 2'b00;
  assign w_acc     = |(req_valid & req_ready);
  assign w_op_sel  = w_gid ? req_op[2*OP_W-1:OP_W]     : req_op[OP_W-1:0];
  assign w_a_sel   = w_gid ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign w_b_sel   = w_gid ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
  assign w_legal   = op_legal(32'(w_op_sel));

`ifdef ALU_LOCK_EN
  logic r_lock_vld, r_lock_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_vld   <= 1'b0;
      r_lock_owner <= 1'b0;
    end else if (w_acc) begin
      if (req_lock[w_gid]) begin
        r_lock_vld   <= 1'b1;
        r_lock_owner <= w_gid;
      end else if (r_lock_vld && (r_lock_owner == w_gid)) begin
        r_lock_vld   <= 1'b0;
      end
    end
  end

  assign w_mask = r_lock_vld ? (r_lock_owner ? 2'b10 : 2'b01) : 2'b11;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^req_lock;
  assign w_mask        = 2'b11;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_nxt = w_legal ? EXEC : RESP;
      EXEC:    w_state_nxt = CAPT;
      CAPT:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Illegal ops bypass the ALU: the response is built entirely at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b0;
    end else if ((r_state == IDLE) && w_acc) begin
      r_op      <= w_op_sel;
      r_a       <= w_a_sel;
      r_b       <= w_b_sel;
      r_id      <= w_gid;
      r_rsp_err <= ~w_legal;
      if (!w_legal) begin
        r_rsp_data  <= '0;
        r_rsp_flags <= alu_flags;
      end
    end else if (r_state == CAPT) begin
      r_rsp_data  <= (r_op == OP_W'(CMP)) ? '0 : alu_result;
      r_rsp_flags <= alu_flags;
    end
  end

  assign alu_instruction = (r_state == EXEC) ? r_op : '0;
  assign alu_num1        = r_a;
  assign alu_num2        = r_b;
  assign rsp_valid       = (r_state == RESP);
  assign rsp_id          = r_id;
  assign rsp_data        = r_rsp_data;
  assign rsp_flags       = r_rsp_flags;
  assign rsp_err         = r_rsp_err;
  assign busy            = (r_state != IDLE);

endmodule
